io_bridge: RTL and testbench



---
 rtl/io_bridge.sv | 178 +++++++++++++++++
 tb/tb_io_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// Memory-mapped I/O endpoint on the CPU byte bus (claims mem_a[17:16] == 2'b11).
// TX FIFO feeding a UART serialiser, RX byte and cycle-counter reads, sticky program stop.
module io_bridge #(
    parameter int FIFO_AW      = 4,
    parameter int CLKS_PER_BIT = 100
) (
    input  logic        clk_in,
    input  logic        rst_in_n,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  io_din,
    output logic        io_sel,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        uart_tx,
    output logic        program_stop
);
    // state   | meaning
    // S_IDLE  | line high, waiting for a byte in the FIFO
    // S_START | start bit (line low)
    // S_DATA  | 8 data bits, LSB first
    // S_STOP  | stop bit (line high); chains straight into S_START if more data
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    localparam int                DEPTH     = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  DEPTH_C   = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]  ALMOST_C  = (FIFO_AW+1)'(DEPTH - 2);
    localparam logic [15:0]       BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

    logic [2:0] offset;
    logic       access, wr_acc, rd_acc;

    assign offset = mem_a[2:0];
    assign access = rdy_in && (mem_a[17:16] == 2'b11);
    assign wr_acc = access && mem_wr;
    assign rd_acc = access && !mem_wr;

    // Remaining address bits take no part in the decode.
    logic unused_addr;
    assign unused_addr = ^{mem_a[31:18], mem_a[15:3]};

    logic [7:0]       fifo_mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count, count_nxt;
    logic             fifo_full, fifo_empty, push_req, push, pop;
    logic [7:0]       push_data, fifo_head;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign push_req   = wr_acc && (((offset == 3'd0) && (mem_dout != 8'h00)) || (offset == 3'd4));
    assign push       = push_req && !fifo_full;
    assign push_data  = (offset == 3'd4) ? 8'h00 : mem_dout;
    assign fifo_head  = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign wr_ptr_nxt = wr_ptr + (FIFO_AW+1)'(push);
    assign rd_ptr_nxt = rd_ptr + (FIFO_AW+1)'(pop);
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr[FIFO_AW-1:0]] <= push_data;
    end

    // Almost-full tracks the post-edge count so the core sees it without extra lag.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            io_buffer_full <= (count_nxt >= ALMOST_C);
        end
    end

    logic [31:0] counter, cnt_latch;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            counter      <= '0;
            cnt_latch    <= '0;
            program_stop <= 1'b0;
            io_din       <= 8'h00;
            io_sel       <= 1'b0;
            rx_pop       <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (wr_acc && (offset == 3'd4)) program_stop <= 1'b1;
            io_sel <= rd_acc;
            rx_pop <= rd_acc && (offset == 3'd0) && rx_valid;
            io_din <= 8'h00;
            if (rd_acc) begin
                case (offset)
                    3'd0: io_din <= rx_valid ? rx_data : 8'h00;
                    3'd4: begin
                        cnt_latch <= counter;
                        io_din    <= counter[7:0];
                    end
                    3'd5: io_din <= cnt_latch[15:8];
                    3'd6: io_din <= cnt_latch[23:16];
                    3'd7: io_din <= cnt_latch[31:24];
                    default: io_din <= 8'h00;
                endcase
            end
        end
    end

    tx_state_t  tx_state, tx_state_nxt;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic        baud_tc;

    assign baud_tc = (baud_cnt == 16'd0);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            tx_state <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_shift <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            baud_cnt <= baud_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            tx_shift <= tx_shift_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        baud_cnt_nxt = baud_tc ? BAUD_LOAD : baud_cnt - 16'd1;
        bit_idx_nxt  = bit_idx;
        tx_shift_nxt = tx_shift;
        pop          = 1'b0;
        case (tx_state)
            S_IDLE: begin
                baud_cnt_nxt = BAUD_LOAD;
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    tx_shift_nxt = fifo_head;
                    tx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    bit_idx_nxt  = 3'd0;
                    tx_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    if (bit_idx == 3'd7) tx_state_nxt = S_STOP;
                    else                 bit_idx_nxt  = bit_idx + 3'd1;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        tx_shift_nxt = fifo_head;
                        tx_state_nxt = S_START;
                    end else begin
                        tx_state_nxt = S_IDLE;
                    end
                end
            end
        endcase
    end

    // Decoded straight from the async-reset state so reset forces the line idle at once.
    assign uart_tx = (tx_state == S_START) ? 1'b0 :
                     (tx_state == S_DATA)  ? tx_shift[bit_idx] : 1'b1;

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge at CLKS_PER_BIT=4: bus decode table, UART frames,
// FIFO almost-full/overflow, counter snapshot and async reset mid-frame.
module tb_io_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in_n = 1'b0;
    logic        rdy_in, mem_wr, rx_valid;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, rx_data;
    logic [7:0]  io_din;
    logic        io_sel, io_buffer_full, rx_pop, uart_tx, program_stop;

    int checks = 0;
    int errors = 0;

    io_bridge #(.FIFO_AW(4), .CLKS_PER_BIT(4)) dut (
        .clk_in(clk_in), .rst_in_n(rst_in_n), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .io_din(io_din), .io_sel(io_sel),
        .io_buffer_full(io_buffer_full), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(rx_pop), .uart_tx(uart_tx), .program_stop(program_stop)
    );

    always #5 clk_in = ~clk_in;

    // Reference cycle counter: zero in reset, +1 per clock afterwards.
    logic [31:0] m_cnt;
    always @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) m_cnt <= '0;
        else           m_cnt <= m_cnt + 32'd1;
    end

    typedef struct {
        logic        rdy;
        logic [31:0] addr;
        logic        wr;
        logic [7:0]  dout;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  exp_din;
        logic        exp_sel;
        logic        exp_pop;
    } vec_t;
    vec_t vecs [12];

    logic [7:0] rx_bytes [17];
    int         rx_wait  [17];
    bit         rx_ok    [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        rdy_in = 1'b1; mem_a = 32'h0; mem_wr = 1'b0; mem_dout = 8'h00;
    endtask

    task automatic write_byte(input logic [31:0] addr, input logic [7:0] data);
        rdy_in = 1'b1; mem_a = addr; mem_wr = 1'b1; mem_dout = data;
        @(posedge clk_in); #1;
        bus_idle();
    endtask

    task automatic expect_idle(input int n, input string name);
        bit ok = 1'b1;
        repeat (n) begin
            @(posedge clk_in); #1;
            if (uart_tx !== 1'b1) ok = 1'b0;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    // Waits (bounded) for a start bit, then checks exact bit timing and collects the byte.
    task automatic get_frame(output logic [7:0] b, output int waited, output bit ok);
        ok = 1'b1; b = 8'h00;
        @(posedge clk_in); #1;
        waited = 1;
        while (uart_tx !== 1'b0 && waited < 400) begin
            @(posedge clk_in); #1;
            waited++;
        end
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
        end else begin
            repeat (3) begin
                @(posedge clk_in); #1;
                if (uart_tx !== 1'b0) ok = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                for (int s = 0; s < 4; s++) begin
                    @(posedge clk_in); #1;
                    if (s == 0) b[i] = uart_tx;
                    else if (uart_tx !== b[i]) ok = 1'b0;
                end
            end
            repeat (4) begin
                @(posedge clk_in); #1;
                if (uart_tx !== 1'b1) ok = 1'b0;
            end
        end
    endtask

    task automatic read_snapshot(input string tag);
        logic [31:0] exp;
        rdy_in = 1'b1; mem_wr = 1'b0; mem_a = 32'h30004;
        exp = m_cnt;
        @(posedge clk_in); #1;
        check({tag, " byte0"}, 32'(io_din), 32'(exp[7:0]));
        mem_a = 32'h30005;
        @(posedge clk_in); #1;
        check({tag, " byte1"}, 32'(io_din), 32'(exp[15:8]));
        mem_a = 32'h30006;
        @(posedge clk_in); #1;
        check({tag, " byte2"}, 32'(io_din), 32'(exp[23:16]));
        mem_a = 32'h30007;
        @(posedge clk_in); #1;
        check({tag, " byte3"}, 32'(io_din), 32'(exp[31:24]));
        bus_idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         w;
        bit         ok;

        //          rdy   addr          wr    dout   rxv   rxd    din    sel   pop
        vecs[0]  = '{1'b1, 32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h7A, 8'h7A, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h7A, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h7A, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h0003_0003, 1'b0, 8'h00, 1'b1, 8'h5C, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h0007_0000, 1'b0, 8'h00, 1'b1, 8'hC3, 8'hC3, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 32'h0002_0000, 1'b0, 8'h00, 1'b1, 8'h7A, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h7A, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h0003_0002, 1'b1, 8'h12, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0003_0000, 1'b1, 8'h33, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h0001_0000, 1'b1, 8'h44, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

        bus_idle();
        rx_valid = 1'b0; rx_data = 8'h00;

        repeat (5) @(posedge clk_in);
        #1;
        check("reset io_din", 32'(io_din), 32'h0);
        check("reset io_sel", 32'(io_sel), 32'h0);
        check("reset io_buffer_full", 32'(io_buffer_full), 32'h0);
        check("reset rx_pop", 32'(rx_pop), 32'h0);
        check("reset uart_tx", 32'(uart_tx), 32'h1);
        check("reset program_stop", 32'(program_stop), 32'h0);
        @(negedge clk_in);
        rst_in_n = 1'b1;

        // 99 edges after release the counter reads 99; the 100th edge samples the read.
        repeat (99) @(posedge clk_in);
        #1;
        mem_a = 32'h30004;
        @(posedge clk_in); #1;
        check("snapshot byte0", 32'(io_din), 32'h63);
        check("snapshot io_sel", 32'(io_sel), 32'h1);
        mem_a = 32'h30005;
        @(posedge clk_in); #1;
        check("snapshot byte1", 32'(io_din), 32'h00);
        mem_a = 32'h30006;
        @(posedge clk_in); #1;
        check("snapshot byte2", 32'(io_din), 32'h00);
        mem_a = 32'h30007;
        @(posedge clk_in); #1;
        check("snapshot byte3", 32'(io_din), 32'h00);
        bus_idle();

        for (int i = 0; i < 12; i++) begin
            rdy_in = vecs[i].rdy; mem_a = vecs[i].addr; mem_wr = vecs[i].wr;
            mem_dout = vecs[i].dout; rx_valid = vecs[i].rxv; rx_data = vecs[i].rxd;
            @(posedge clk_in); #1;
            check($sformatf("vec%0d io_sel", i), 32'(io_sel), 32'(vecs[i].exp_sel));
            check($sformatf("vec%0d rx_pop", i), 32'(rx_pop), 32'(vecs[i].exp_pop));
            if (vecs[i].exp_sel) check($sformatf("vec%0d io_din", i), 32'(io_din), 32'(vecs[i].exp_din));
        end
        bus_idle();
        rx_valid = 1'b0;
        expect_idle(10, "ignored writes leave line idle");
        check("program_stop still clear", 32'(program_stop), 32'h0);

        write_byte(32'h30000, 8'h41);
        check("0x41 line high at t+1", 32'(uart_tx), 32'h1);
        get_frame(b, w, ok);
        check("0x41 start at t+2", 32'(w), 32'd1);
        check("0x41 frame timing", 32'(ok), 32'd1);
        check("0x41 frame data", 32'(b), 32'h41);
        expect_idle(20, "fifo empty after 0x41");

        write_byte(32'h30004, 8'h55);
        check("program_stop set", 32'(program_stop), 32'h1);
        get_frame(b, w, ok);
        check("stop frame timing", 32'(ok), 32'd1);
        check("stop frame data", 32'(b), 32'h00);
        expect_idle(10, "idle after stop frame");

        // 18 back-to-back writes: the first is taken by the serialiser, 16 fill the
        // FIFO, the 18th is dropped.
        fork
            begin
                for (int j = 1; j <= 18; j++) begin
                    rdy_in = 1'b1; mem_a = 32'h30000; mem_wr = 1'b1; mem_dout = 8'(8'h10 + j);
                    @(posedge clk_in); #1;
                    check($sformatf("burst %0d io_buffer_full", j), 32'(io_buffer_full), (j >= 15) ? 32'd1 : 32'd0);
                end
                bus_idle();
            end
            begin
                for (int k = 0; k < 17; k++) get_frame(rx_bytes[k], rx_wait[k], rx_ok[k]);
            end
        join
        for (int k = 0; k < 17; k++) begin
            check($sformatf("burst frame %0d timing", k), 32'(rx_ok[k]), 32'd1);
            check($sformatf("burst frame %0d data", k), 32'(rx_bytes[k]), 32'(8'h11 + k));
            if (k > 0) check($sformatf("burst frame %0d no gap", k), 32'(rx_wait[k]), 32'd1);
        end
        check("io_buffer_full clear after drain", 32'(io_buffer_full), 32'h0);
        expect_idle(60, "18th byte dropped");

        read_snapshot("model snapshot");

        write_byte(32'h30004, 8'h55);
        write_byte(32'h30000, 8'h11);
        write_byte(32'h30000, 8'h22);
        repeat (6) @(posedge clk_in);
        #1;
        check("mid-data line low", 32'(uart_tx), 32'h0);
        #2;
        rst_in_n = 1'b0;
        #1;
        check("async reset uart_tx", 32'(uart_tx), 32'h1);
        check("async reset program_stop", 32'(program_stop), 32'h0);
        check("async reset io_buffer_full", 32'(io_buffer_full), 32'h0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        expect_idle(60, "fifo discarded by reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
